stream_rr_arb: RTL and testbench

//  Round-robin arbiter sharing one mFifo sink port among p_num_req valid/ready

---
 rtl/stream_rr_arb_if.sv | 38 +++
 rtl/stream_rr_arb.sv | 118 +++++++++++
 tb/tb_stream_rr_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_rr_arb_if.sv
// Handshake bundle between the round-robin arbiter, its requesters and the FIFO sink.
// The master modport is the arbiter's view; the slave modport is the environment's.
interface stream_rr_arb_if #(
    parameter int p_st_bits      = 32,
    parameter int p_num_req      = 4,
    parameter int p_num_req_log2 = 2
);
    logic [p_num_req*p_st_bits-1:0] i_snk_data;
    logic [p_num_req-1:0]           i_snk_valid;
    logic [p_num_req-1:0]           o_snk_ready;
    logic [p_st_bits-1:0]           o_src_data;
    logic                           o_src_valid;
    logic                           i_src_ready;
    logic [p_num_req_log2-1:0]      o_grant_id;
    logic                           o_busy;

    modport master (
        input  i_snk_data,
        input  i_snk_valid,
        input  i_src_ready,
        output o_snk_ready,
        output o_src_data,
        output o_src_valid,
        output o_grant_id,
        output o_busy
    );

    modport slave (
        output i_snk_data,
        output i_snk_valid,
        output i_src_ready,
        input  o_snk_ready,
        input  o_src_data,
        input  o_src_valid,
        input  o_grant_id,
        input  o_busy
    );
endinterface

// File: rtl/stream_rr_arb.sv
// Round-robin arbiter: one requester at a time owns the FIFO sink for a burst of
// up to p_max_burst beats. Arbitration happens in IDLE (one bubble per grant);
// the datapath in BURST is a pure combinational passthrough of the granted slice.
module stream_rr_arb #(
    parameter int p_st_bits      = 32,
    parameter int p_num_req      = 4,
    parameter int p_num_req_log2 = 2,
    parameter int p_max_burst    = 4,
    parameter int p_burst_log2   = 3
) (
    input  logic               clk,
    input  logic               rst,
    stream_rr_arb_if.master    bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [p_burst_log2-1:0]   LAST_BEAT = p_burst_log2'(p_max_burst - 1);
    localparam logic [p_num_req_log2-1:0] LAST_ID   = p_num_req_log2'(p_num_req - 1);

    state_t                    state_q, state_d;
    logic [p_num_req_log2-1:0] grant_q, grant_d;
    logic [p_burst_log2-1:0]   cnt_q,   cnt_d;
    logic [p_num_req_log2-1:0] last_q,  last_d;

    logic [p_num_req_log2:0]   pick;
    logic                      grant_valid;

    // Rotating priority search: first valid requester after the last one served.
    // Result is {found, id}.
    function automatic logic [p_num_req_log2:0] rr_pick(
        input logic [p_num_req-1:0]      req,
        input logic [p_num_req_log2-1:0] last
    );
        logic                      found;
        logic [p_num_req_log2-1:0] id;
        int                        idx;
        found = 1'b0;
        id    = '0;
        for (int i = 1; i <= p_num_req; i++) begin
            idx = int'(last) + i;
            if (idx >= p_num_req) begin
                idx = idx - p_num_req;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = p_num_req_log2'(idx);
            end
        end
        return {found, id};
    endfunction

    assign pick        = rr_pick(bus.i_snk_valid, last_q);
    assign grant_valid = bus.i_snk_valid[grant_q];

    // Control state; reset restarts priority at requester 0 and drops any in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            last_q  <= LAST_ID;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state and outputs: arbitrate in IDLE, pass the granted stream through in BURST.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        cnt_d           = cnt_q;
        last_d          = last_q;
        bus.o_src_valid = 1'b0;
        bus.o_src_data  = '0;
        bus.o_snk_ready = '0;
        bus.o_busy      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pick[p_num_req_log2]) begin
                    grant_d = pick[p_num_req_log2-1:0];
                    cnt_d   = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                bus.o_busy               = 1'b1;
                bus.o_src_valid          = grant_valid;
                bus.o_src_data           = bus.i_snk_data[int'(grant_q)*p_st_bits +: p_st_bits];
                bus.o_snk_ready[grant_q] = bus.i_src_ready;
                if (!grant_valid) begin
                    // Requester went quiet: give the port up without a transfer.
                    state_d = S_IDLE;
                    last_d  = grant_q;
                end else if (bus.i_src_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.o_grant_id = grant_q;

endmodule

// File: tb/tb_stream_rr_arb.sv
// Bench for stream_rr_arb: queue-backed requesters, a transaction-level owner model
// compared every cycle, and directed scenarios with hand-computed beat logs.
module tb_stream_rr_arb;
    localparam int SB  = 32;
    localparam int NR  = 4;
    localparam int NRL = 2;
    localparam int MB  = 4;
    localparam int BL  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stream_rr_arb_if #(.p_st_bits(SB), .p_num_req(NR), .p_num_req_log2(NRL)) bus ();

    stream_rr_arb #(
        .p_st_bits(SB), .p_num_req(NR), .p_num_req_log2(NRL),
        .p_max_burst(MB), .p_burst_log2(BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    // Requester state: pending beats per requester, enable, FIFO readiness
    logic [SB-1:0] q [NR][$];
    bit            en [NR];
    logic          src_rdy;
    logic [NR-1:0] beat_seen = '0;

    // Observed FIFO-side beats
    logic [SB-1:0] log_data [$];
    int            log_gid  [$];
    int            log_cyc  [$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Owner model: -1 means nobody owns the port
    int m_owner = -1;
    int m_last  = NR - 1;
    int m_cnt   = 0;
    int m_gid   = 0;

    function automatic logic [SB-1:0] filler(int k);
        return 32'hDEAD_0000 + k;
    endfunction

    function automatic bit req_now(int k);
        return en[k] && (q[k].size() > 0);
    endfunction

    function automatic bit any_pending();
        for (int k = 0; k < NR; k++) begin
            if (req_now(k)) return 1'b1;
        end
        return m_owner >= 0;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            bus.i_snk_valid[k]            = req_now(k);
            bus.i_snk_data[k*SB +: SB]    = (q[k].size() > 0) ? q[k][0] : filler(k);
        end
        bus.i_src_ready = src_rdy;
    endtask

    // One clock: requesters retire beats accepted last cycle, then re-present.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (beat_seen[k]) void'(q[k].pop_front());
        end
        drive();
    endtask

    task automatic do_reset();
        for (int k = 0; k < NR; k++) begin
            q[k].delete();
            en[k] = 1'b1;
        end
        src_rdy = 1'b1;
        drive();
        rst = 1'b1;
        step();
        rst = 1'b0;
        log_data.delete();
        log_gid.delete();
        log_cyc.delete();
    endtask

    task automatic wait_drain(string name, int maxc);
        int n;
        n = 0;
        while (any_pending() && n < maxc) begin
            step();
            n++;
        end
        chk(name, 64'(n < maxc), 64'd1);
    endtask

    task automatic wait_log(string name, int cnt, int maxc);
        int n;
        n = 0;
        while (log_data.size() < cnt && n < maxc) begin
            step();
            n++;
        end
        chk(name, 64'(n < maxc), 64'd1);
    endtask

    always @(posedge clk) cyc++;

    // Model advance on the active edge using what the requesters presented
    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_last  = NR - 1;
            m_cnt   = 0;
            m_gid   = 0;
        end else if (m_owner < 0) begin
            bit found;
            found = 1'b0;
            for (int i = 1; i <= NR; i++) begin
                int k;
                k = (m_last + i) % NR;
                if (!found && req_now(k)) begin
                    found   = 1'b1;
                    m_owner = k;
                    m_gid   = k;
                    m_cnt   = 0;
                end
            end
        end else begin
            if (!req_now(m_owner)) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (src_rdy) begin
                m_cnt++;
                if (m_cnt == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    // Compare on the inactive edge; also log beats accepted by the FIFO
    always @(negedge clk) begin
        logic [NR-1:0] er;
        logic [NR-1:0] one;
        logic [SB-1:0] ed;
        logic          ev;
        logic          eb;
        int            eg;
        one       = 1;
        beat_seen = bus.i_snk_valid & bus.o_snk_ready;
        if (bus.o_src_valid && bus.i_src_ready) begin
            log_data.push_back(bus.o_src_data);
            log_gid.push_back(int'(bus.o_grant_id));
            log_cyc.push_back(cyc);
        end
        if (rst || m_owner < 0) begin
            ev = 1'b0;
            ed = '0;
            er = '0;
            eb = 1'b0;
            eg = rst ? 0 : m_gid;
        end else begin
            ev = req_now(m_owner);
            ed = (q[m_owner].size() > 0) ? q[m_owner][0] : filler(m_owner);
            er = src_rdy ? (one << m_owner) : '0;
            eb = 1'b1;
            eg = m_owner;
        end
        chk("src_valid", 64'(bus.o_src_valid), 64'(ev));
        chk("src_data",  64'(bus.o_src_data),  64'(ed));
        chk("snk_ready", 64'(bus.o_snk_ready), 64'(er));
        chk("busy",      64'(bus.o_busy),      64'(eb));
        chk("grant_id",  64'(bus.o_grant_id),  64'(eg));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        src_rdy = 1'b1;
        for (int k = 0; k < NR; k++) en[k] = 1'b1;
        rst = 1'b1;
        drive();
        step();
        step();
        chk("rst_busy",  64'(bus.o_busy),      64'd0);
        chk("rst_gid",   64'(bus.o_grant_id),  64'd0);
        chk("rst_valid", 64'(bus.o_src_valid), 64'd0);
        chk("rst_ready", 64'(bus.o_snk_ready), 64'd0);
        rst = 1'b0;
        step();

        // Async reset in the middle of a cycle while requester 2 is bursting
        q[2].push_back(32'h1);
        q[2].push_back(32'h2);
        drive();
        step();
        chk("t1_busy_pre",  64'(bus.o_busy),      64'd1);
        chk("t1_gid_pre",   64'(bus.o_grant_id),  64'd2);
        chk("t1_valid_pre", 64'(bus.o_src_valid), 64'd1);
        chk("t1_data_pre",  64'(bus.o_src_data),  64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_valid", 64'(bus.o_src_valid), 64'd0);
        chk("t1_ready", 64'(bus.o_snk_ready), 64'd0);
        chk("t1_data",  64'(bus.o_src_data),  64'd0);
        chk("t1_busy",  64'(bus.o_busy),      64'd0);
        chk("t1_gid",   64'(bus.o_grant_id),  64'd0);
        step();
        rst = 1'b0;
        q[2].delete();
        drive();
        step();

        // Single requester streaming: 4 beats, one bubble, then the rest
        log_data.delete(); log_gid.delete(); log_cyc.delete();
        c0 = cyc;
        for (int i = 0; i < 8; i++) q[2].push_back(32'hA0 + i);
        drive();
        wait_drain("t2_drain", 40);
        chk("t2_count", 64'(log_data.size()), 64'd8);
        if (log_data.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("t2_data", 64'(log_data[i]), 64'(32'hA0 + i));
                chk("t2_gid",  64'(log_gid[i]),  64'd2);
            end
            chk("t2_latency", 64'(log_cyc[0] - c0),          64'd1);
            chk("t2_burst",   64'(log_cyc[3] - log_cyc[0]),  64'd3);
            chk("t2_bubble",  64'(log_cyc[4] - log_cyc[3]),  64'd2);
        end

        // Full contention: order 0,1,2,3,0 with 4 beats per grant
        do_reset();
        c0 = cyc;
        for (int k = 0; k < NR; k++)
            for (int i = 0; i < 8; i++) q[k].push_back(32'h100 * k + i);
        drive();
        wait_drain("t3_drain", 100);
        chk("t3_count", 64'(log_data.size()), 64'd32);
        if (log_data.size() == 32) begin
            for (int j = 0; j < 20; j++) begin
                chk("t3_gid",  64'(log_gid[j]),  64'((j / 4) % 4));
                chk("t3_data", 64'(log_data[j]),
                    64'(32'h100 * ((j / 4) % 4) + (j / 16) * 4 + (j % 4)));
            end
            chk("t3_first", 64'(log_cyc[0] - c0),          64'd1);
            chk("t3_span",  64'(log_cyc[19] - log_cyc[0]), 64'd23);
        end

        // Backpressure mid-burst holds grant, data and beat count
        do_reset();
        for (int i = 0; i < 4; i++) q[1].push_back(32'hB0 + i);
        drive();
        wait_log("t4_wait", 2, 10);
        src_rdy = 1'b0;
        drive();
        for (int s = 0; s < 3; s++) begin
            #2;
            chk("t4_hold_data",  64'(bus.o_src_data),  64'hB2);
            chk("t4_hold_gid",   64'(bus.o_grant_id),  64'd1);
            chk("t4_hold_ready", 64'(bus.o_snk_ready), 64'd0);
            step();
        end
        src_rdy = 1'b1;
        drive();
        wait_drain("t4_drain", 20);
        chk("t4_count", 64'(log_data.size()), 64'd4);
        if (log_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t4_data", 64'(log_data[i]), 64'(32'hB0 + i));
                chk("t4_gid",  64'(log_gid[i]),  64'd1);
            end
            chk("t4_stall", 64'(log_cyc[2] - log_cyc[1]), 64'd4);
            chk("t4_tail",  64'(log_cyc[3] - log_cyc[2]), 64'd1);
        end

        // Early release by requester 1, requester 3 takes over, then rotation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q[1].push_back(32'h10 + i);
            q[3].push_back(32'h30 + i);
        end
        drive();
        wait_log("t5_wait_a", 2, 10);
        en[1] = 1'b0;
        drive();
        wait_log("t5_wait_b", 3, 10);
        en[1] = 1'b1;
        drive();
        wait_drain("t5_drain", 60);
        chk("t5_count", 64'(log_data.size()), 64'd8);
        if (log_data.size() == 8) begin
            logic [SB-1:0] exp_d [8];
            int            exp_g [8];
            exp_d = '{32'h10, 32'h11, 32'h30, 32'h31, 32'h32, 32'h33, 32'h12, 32'h13};
            exp_g = '{1, 1, 3, 3, 3, 3, 1, 1};
            for (int i = 0; i < 8; i++) begin
                chk("t5_data", 64'(log_data[i]), 64'(exp_d[i]));
                chk("t5_gid",  64'(log_gid[i]),  64'(exp_g[i]));
            end
            chk("t5_release", 64'(log_cyc[2] - log_cyc[1]), 64'd3);
        end

        // Reset during requester 3's burst: priority restarts at 0, no duplicate beat
        do_reset();
        for (int i = 0; i < 4; i++) q[3].push_back(32'h60 + i);
        drive();
        wait_log("t6_wait_a", 1, 10);
        for (int i = 0; i < 4; i++) q[0].push_back(32'h50 + i);
        drive();
        wait_log("t6_wait_b", 2, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", 64'(bus.o_src_valid), 64'd0);
        chk("t6_ready", 64'(bus.o_snk_ready), 64'd0);
        step();
        rst = 1'b0;
        wait_drain("t6_drain", 80);
        chk("t6_count", 64'(log_data.size()), 64'd8);
        if (log_data.size() == 8) begin
            logic [SB-1:0] exp_d [8];
            int            exp_g [8];
            exp_d = '{32'h60, 32'h61, 32'h50, 32'h51, 32'h52, 32'h53, 32'h62, 32'h63};
            exp_g = '{3, 3, 0, 0, 0, 0, 3, 3};
            for (int i = 0; i < 8; i++) begin
                chk("t6_data", 64'(log_data[i]), 64'(exp_d[i]));
                chk("t6_gid",  64'(log_gid[i]),  64'(exp_g[i]));
            end
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
